// File: rtl/fifo_read_drain.sv
// fifo_read_drain: read-side drain stage feeding a 2-entry skid buffer on a valid/ready stream.
// Define DRAIN_CNT_EN to add the drained_cnt pop counter (width CNT_WIDTH).
package pkg;
  localparam int DATA_WIDTH = 8;
endpackage

module fifo_read_drain #(
  parameter int DATA_WIDTH = pkg::DATA_WIDTH
`ifdef DRAIN_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_req,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef DRAIN_CNT_EN
  , output logic [CNT_WIDTH-1:0] drained_cnt
`endif
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0] buf_cnt, buf_cnt_n;
  logic inflight, pop, wr_idx;
  logic [2:0] occ;
  logic [DATA_WIDTH-1:0] head, tail, head_n, tail_n;
  assign pop = (buf_cnt != EMPTY) && out_ready;
  // occupancy after this cycle, counting the word still in flight
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      buf_cnt <= EMPTY;
      inflight <= 1'b0;
      head <= '0;
      tail <= '0;
    end else begin
      buf_cnt <= buf_cnt_n;
      inflight <= rd_req;
      head <= head_n;
      tail <= tail_n;
    end
  end
  always_comb begin
    buf_cnt_n = occ[1:0];
    wr_idx = (buf_cnt == FULL) || (buf_cnt == ONE && !pop);
    head_n = (inflight && !wr_idx) ? data_out : pop ? tail : head;
    tail_n = (inflight && wr_idx) ? data_out : tail;
  end
  always_comb begin
    out_valid = buf_cnt != EMPTY;
    out_data = head;
    rd_req = !rrst && drain_en && !fifo_empty && (occ < 3'd2);
  end
`ifdef DRAIN_CNT_EN
  always_ff @(posedge r_clk) drained_cnt <= rrst ? '0 : drained_cnt + CNT_WIDTH'(pop);
`endif
endmodule

// File: tb/tb_fifo_read_drain.sv
// tb_fifo_read_drain: directed bench with a behavioural FIFO read port and an output monitor.
module tb_fifo_read_drain;
  localparam int W = pkg::DATA_WIDTH;
  logic r_clk = 0, rrst = 1, drain_en = 0, out_ready = 0;
  logic fifo_empty, rd_req, out_valid;
  logic [W-1:0] data_out = '0, out_data;
`ifdef DRAIN_CNT_EN
  logic [3:0] drained_cnt;
`endif
  logic [W-1:0] mem [256];
  logic [7:0] rd_ptr = 0, wr_ptr = 0;
  logic [W-1:0] out_q [$];
  int tests = 0, fails = 0;

`ifdef DRAIN_CNT_EN
  fifo_read_drain #(.CNT_WIDTH(4)) dut (.r_clk(r_clk), .rrst(rrst), .drain_en(drain_en),
    .fifo_empty(fifo_empty), .data_out(data_out), .rd_req(rd_req), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .drained_cnt(drained_cnt));
`else
  fifo_read_drain dut (.r_clk(r_clk), .rrst(rrst), .drain_en(drain_en),
    .fifo_empty(fifo_empty), .data_out(data_out), .rd_req(rd_req), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready));
`endif

  always #5 r_clk = ~r_clk;
  assign fifo_empty = rd_ptr == wr_ptr;
  always @(posedge r_clk) if (rd_req) begin
    data_out <= mem[rd_ptr];
    rd_ptr <= rd_ptr + 8'd1;
  end
  always @(negedge r_clk) if (!rrst && out_valid && out_ready) out_q.push_back(out_data);
  always @(negedge r_clk) if (!rrst && (dut.buf_cnt + dut.inflight > 2)) begin
    fails++;
    $display("FAIL occupancy: buf_cnt+inflight=%0d, required <= 2", dut.buf_cnt + dut.inflight);
  end

  task automatic tick; @(posedge r_clk); #1; endtask
  task automatic push(input logic [W-1:0] v); mem[wr_ptr] = v; wr_ptr = wr_ptr + 8'd1; endtask

  task automatic test_reset;
    rrst = 1; drain_en = 1; out_ready = 1; out_q.delete(); push(W'(8'h77));
    repeat (3) begin
      tick; @(negedge r_clk); tests++;
      if (rd_req !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
        fails++;
        $display("FAIL reset_hold: rd_req=%b out_valid=%b out_data=%h, required 0 0 00", rd_req, out_valid, out_data);
      end
    end
`ifdef DRAIN_CNT_EN
    tests++;
    if (drained_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d, required 0", drained_cnt); end
`endif
    tick; rrst = 0; @(negedge r_clk); tests++;
    if (rd_req !== 1'b1) begin fails++; $display("FAIL reset_release_req: rd_req=%b, required 1", rd_req); end
    for (int k = 0; k < 20 && out_q.size() < 1; k++) tick;
    tests++;
    if (out_q.size() != 1 || out_q[0] !== W'(8'h77)) begin
      fails++; $display("FAIL reset_first_word: %0d words, first %h, required 1 word 77", out_q.size(), out_q.size() ? out_q[0] : '0);
    end
    repeat (2) tick;
  endtask

  task automatic test_stream;
    int first_req = -1, first_val = -1, last_val = -1, nval = 0;
    out_q.delete(); drain_en = 0; out_ready = 1;
    for (int i = 1; i <= 16; i++) push(W'(i));
    tick; drain_en = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge r_clk);
      if (rd_req && first_req < 0) first_req = c;
      if (out_valid) begin
        if (first_val < 0) first_val = c;
        last_val = c; nval++;
      end
      tick;
    end
    tests++;
    if (first_val - first_req != 2) begin fails++; $display("FAIL stream_latency: got %0d, required 2", first_val - first_req); end
    tests++;
    if (nval != 16 || last_val - first_val != 15) begin
      fails++; $display("FAIL stream_rate: %0d valid cycles over span %0d, required 16 over 15", nval, last_val - first_val);
    end
    tests++;
    if (out_q.size() != 16) begin fails++; $display("FAIL stream_count: got %0d, required 16", out_q.size()); end
    for (int i = 0; i < 16 && i < out_q.size(); i++) begin
      tests++;
      if (out_q[i] !== W'(i + 1)) begin fails++; $display("FAIL stream_word%0d: got %h, required %h", i, out_q[i], W'(i + 1)); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] held = '0;
    int start, bad = 0;
    out_q.delete(); drain_en = 0; out_ready = 1;
    for (int i = 0; i < 16; i++) push(W'(8'h20 + i));
    start = int'(rd_ptr);
    tick; drain_en = 1;
    for (int k = 0; k < 50 && out_q.size() < 3; k++) tick;
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge r_clk);
      if (c == 0) held = out_data;
      if (rd_req !== 1'b0 || out_valid !== 1'b1 || out_data !== held) bad++;
      tick;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_stall: %0d bad stall cycles, required 0", bad); end
    tests++;
    if (held !== W'(8'h23)) begin fails++; $display("FAIL bp_head: got %h, required 23", held); end
    tests++;
    if (int'(rd_ptr) - start - out_q.size() != 2) begin
      fails++; $display("FAIL bp_buffered: got %0d, required 2", int'(rd_ptr) - start - out_q.size());
    end
    out_ready = 1;
    for (int k = 0; k < 60 && out_q.size() < 16; k++) tick;
    repeat (3) tick;
    tests++;
    if (out_q.size() != 16) begin fails++; $display("FAIL bp_count: got %0d, required 16", out_q.size()); end
    for (int i = 0; i < 16 && i < out_q.size(); i++) begin
      tests++;
      if (out_q[i] !== W'(8'h20 + i)) begin fails++; $display("FAIL bp_word%0d: got %h, required %h", i, out_q[i], W'(8'h20 + i)); end
    end
  endtask

  task automatic test_empty_boundary;
    int nreq = 0, nval = 0, bad = 0;
    out_q.delete(); out_ready = 1; drain_en = 1; push(W'(8'hA5));
    for (int c = 0; c < 10; c++) begin
      @(negedge r_clk);
      if (rd_req) nreq++;
      if (rd_req && fifo_empty) bad++;
      if (out_valid) nval++;
      tick;
    end
    tests++;
    if (nreq != 1) begin fails++; $display("FAIL empty_req: got %0d pulses, required 1", nreq); end
    tests++;
    if (nval != 1) begin fails++; $display("FAIL empty_valid: got %0d cycles, required 1", nval); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL empty_req_when_empty: got %0d, required 0", bad); end
    tests++;
    if (out_q.size() != 1 || out_q[0] !== W'(8'hA5)) begin
      fails++; $display("FAIL empty_word: %0d words, first %h, required 1 word a5", out_q.size(), out_q.size() ? out_q[0] : '0);
    end
  endtask

  task automatic test_pause;
    int bad = 0;
    out_q.delete(); drain_en = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) push(W'(8'h30 + i));
    tick; drain_en = 1;
    @(negedge r_clk); tests++;
    if (rd_req !== 1'b1) begin fails++; $display("FAIL pause_issue: rd_req=%b, required 1", rd_req); end
    tick; drain_en = 0;
    repeat (6) begin @(negedge r_clk); if (rd_req !== 1'b0) bad++; tick; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL pause_req: %0d requests while paused, required 0", bad); end
    tests++;
    if (out_q.size() != 1 || out_q[0] !== W'(8'h30)) begin
      fails++; $display("FAIL pause_inflight: %0d words, first %h, required 1 word 30", out_q.size(), out_q.size() ? out_q[0] : '0);
    end
    drain_en = 1;
    for (int k = 0; k < 30 && out_q.size() < 4; k++) tick;
    repeat (3) tick;
    tests++;
    if (out_q.size() != 4) begin fails++; $display("FAIL pause_count: got %0d, required 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests++;
      if (out_q[i] !== W'(8'h30 + i)) begin fails++; $display("FAIL pause_word%0d: got %h, required %h", i, out_q[i], W'(8'h30 + i)); end
    end
  endtask

`ifdef DRAIN_CNT_EN
  task automatic test_drain_cnt;
    rrst = 1; tick; rrst = 0;
    out_q.delete(); out_ready = 1; drain_en = 1;
    for (int i = 0; i < 17; i++) push(W'(8'h40 + i));
    for (int k = 0; k < 60 && out_q.size() < 17; k++) tick;
    repeat (3) tick;
    @(negedge r_clk); tests++;
    if (drained_cnt !== 4'd1) begin fails++; $display("FAIL cnt_wrap: got %0d, required 1", drained_cnt); end
    tick; rrst = 1; tick;
    @(negedge r_clk); tests++;
    if (drained_cnt !== 4'd0) begin fails++; $display("FAIL cnt_reset: got %0d, required 0", drained_cnt); end
    tick; rrst = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_empty_boundary;
    test_pause;
`ifdef DRAIN_CNT_EN
    test_drain_cnt;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fifo_read_drain.md
# fifo_read_drain

Read-side drain stage for the dual-clock FIFO. Sits in the `r_clk` domain directly downstream of the FIFO read port. It issues `rd_req` whenever the FIFO is non-empty and it has room, and captures `data_out` one cycle later into a 2-entry output buffer. It presents the words on a valid/ready stream at full rate (one word per cycle) with lossless backpressure.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH` from `pkg`: word width; must match the FIFO.
- `CNT_WIDTH`, default 16: width of the drained-word counter (only used when `DRAIN_CNT_EN` is defined).

Ports:
- `r_clk`  input  1  read-domain clock; all logic is on its rising edge.
- `rrst`  input  1  synchronous, active-high reset.
- `drain_en`  input  1  when low, no new `rd_req` is issued; in-flight and buffered words still drain.
- `fifo_empty`  input  1  FIFO empty flag, `r_clk` domain.
- `data_out`  input  `DATA_WIDTH`  FIFO read data, valid exactly one cycle after an `rd_req` cycle.
- `rd_req`  output  1  FIFO read strobe, one word per high cycle.
- `out_valid`  output  1  head-of-buffer word available.
- `out_data`  output  `DATA_WIDTH`  head-of-buffer word.
- `out_ready`  input  1  consumer accepts when `out_valid && out_ready`.
- `drained_cnt`  output  `CNT_WIDTH`  count of words accepted downstream (only with `DRAIN_CNT_EN`).

## Operation
- State is `buf_cnt` ∈ {EMPTY=0, ONE=1, FULL=2} plus a 1-bit `inflight` flag (an `rd_req` was issued last cycle).
- `pop = out_valid && out_ready`.
- `rd_req = !rrst && drain_en && !fifo_empty && (buf_cnt + inflight - pop < 2)`. This is combinational; `rd_req` is never asserted while `fifo_empty` is high.
- `inflight` register: next value = `rd_req`.
- Capture: when `inflight` is set, `data_out` is written into the buffer tail in that cycle.
- Buffer: 2-entry register FIFO. `out_valid = (buf_cnt != 0)`. `out_data` is the head entry.
- `buf_cnt` next value = `buf_cnt + inflight - pop`.
  - EMPTY→ONE on capture without pop.
  - ONE→FULL on capture without pop.
  - ONE→EMPTY on pop without capture.
  - FULL→ONE on pop without capture.
  - Simultaneous capture and pop: count unchanged, the head advances, and the new word lands behind the remaining word. In EMPTY, capture+pop cannot occur since `pop` requires `out_valid`.
- Ordering: words leave in exactly FIFO read order. No word is dropped or duplicated.
- Overflow is impossible by construction (the issue condition reserves space for the in-flight word). The bench asserts `buf_cnt + inflight <= 2` at all times.
- `drain_en` falling: any word already in flight is still captured. `out_valid` continues until the buffer empties.
- `out_data` is held stable while `out_valid && !out_ready`.

## Timing
- Reset values (cycle after `rrst` is sampled high): `buf_cnt=0`, `inflight=0`, `out_valid=0`, `rd_req=0`, `out_data=0`, `drained_cnt=0`.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO read side is reset by the same `rrst`.
- Latency: `rd_req` at cycle t → `data_out` captured at the end of t+1 → `out_valid=1` with that word at t+2.
- Throughput: one word per cycle sustained while `fifo_empty=0` and `out_ready=1`. The steady state is `buf_cnt=1`, `inflight=1`.
- Backpressure: with `out_ready=0`, at most 2 words are read past the point where the consumer stalls; `rd_req` drops within one cycle.

## Configuration
- `DRAIN_CNT_EN` defined: `drained_cnt` is present and increments by 1 on every `pop`. It wraps modulo 2^`CNT_WIDTH`, with no saturation, and is cleared by `rrst`.
- `DRAIN_CNT_EN` undefined: the `drained_cnt` port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rrst=1` for 3 cycles with `fifo_empty=0` → `rd_req=0`, `out_valid=0`, `out_data=0` throughout; first `rd_req` occurs in the cycle after `rrst` deasserts.
- Streaming: FIFO preloaded with 0x01..0x10, `out_ready=1` → 16 words out in order on 16 consecutive cycles, first `out_valid` 2 cycles after first `rd_req`.
- Backpressure: stream 0x20..0x2F, drop `out_ready` for 5 cycles mid-stream → exactly 2 words buffered, `rd_req` low during stall, no loss or duplication, output is 0x20..0x2F.
- Empty boundary: FIFO holds 1 word (0xA5) → exactly one `rd_req` pulse; `out_valid` for one cycle with 0xA5; no `rd_req` while `fifo_empty=1`.
- Pause: deassert `drain_en` the same cycle an `rd_req` is issued → that word is still delivered, then no further `rd_req` until `drain_en=1`.
- `DRAIN_CNT_EN` with `CNT_WIDTH=4`: 17 pops → `drained_cnt=1` (wrap). Assert `rrst` → `drained_cnt=0` the next cycle.
